l2_fill_ctrl: RTL and testbench

L2_FILL_CTRL -- requirements
Module: l2_fill_ctrl

---
 rtl/cache_pkg.sv | 31 +++
 rtl/l2_fill_ctrl_if.sv | 37 +++
 rtl/l2_tag_store.sv | 50 +++++
 rtl/l2_fill_ctrl.sv | 145 ++++++++++++++
 tb/tb_l2_fill_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions used by both the L1 and L2 controllers.
// Holds the fill-controller state encoding, default geometry values and the
// helper functions that derive tag/index/offset widths from that geometry.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    MEM_WAIT = 2'd2,
    FILL     = 2'd3
  } fill_state_e;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_SETS   = 16;
  localparam int DEF_BLOCK_SIZE = 16;

  function automatic int offset_bits(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int index_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // Whatever is left above index and offset forms the tag.
  function automatic int tag_bits(input int addr_width, input int num_sets, input int block_size);
    return addr_width - index_bits(num_sets) - offset_bits(block_size);
  endfunction

endpackage

// File: rtl/l2_fill_ctrl_if.sv
// Bus bundle between the L2 fill controller, the L1 that requests fills and
// the backing memory.
//   req_valid/req_addr/req_ready       : L1 miss request handshake
//   fill_valid/fill_addr/fill_data/hit : one-cycle line promote into L1
//   mem_req/mem_addr/mem_ack/mem_rdata : backing-memory read
// Modport slave is the controller side; modport master is the requester and
// memory side.
interface l2_fill_ctrl_if
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_ready;
  logic                  fill_valid;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  fill_hit;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_addr, mem_ack, mem_rdata,
    input  req_ready, fill_valid, fill_addr, fill_data, fill_hit, mem_req, mem_addr
  );

  modport slave (
    input  req_valid, req_addr, mem_ack, mem_rdata,
    output req_ready, fill_valid, fill_addr, fill_data, fill_hit, mem_req, mem_addr
  );

endinterface

// File: rtl/l2_tag_store.sv
// Direct-mapped L2 storage: valid bits, tags and line data.
// Ports:
//   clk, rst                    : clock, async active-high reset (valid bits only)
//   rd_index -> rd_valid/tag/data : combinational lookup port
//   wr_en, wr_index/tag/data    : write port, sets the valid bit of the set
module l2_tag_store
  import cache_pkg::*;
#(
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int INDEX_W    = 4,
  parameter int TAG_W      = 3,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [NUM_SETS-1:0]   valid_q;
  logic [TAG_W-1:0]      tag_mem  [NUM_SETS];
  logic [DATA_WIDTH-1:0] data_mem [NUM_SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are never trusted while valid is clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/l2_fill_ctrl.sv
// L2 fill controller: accepts L1 miss requests, looks the line up in the
// direct-mapped L2, fetches it from backing memory on an L2 miss and
// promotes the line into L1 with a one-cycle fill strobe.
// Ports:
//   clk, rst               : clock, async active-high reset
//   bus (slave)            : request, fill and memory signals
//   hit_count, miss_count  : saturating L2 hit/miss statistics
module l2_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
) (
  input  logic           clk,
  input  logic           rst,
  l2_fill_ctrl_if.slave  bus,
  output logic [15:0]    hit_count,
  output logic [15:0]    miss_count
);

  localparam int OFFSET_W = offset_bits(BLOCK_SIZE);
  localparam int INDEX_W  = index_bits(NUM_SETS);
  localparam int TAG_W    = tag_bits(ADDR_WIDTH, NUM_SETS, BLOCK_SIZE);

  fill_state_e state, state_next;

  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [ADDR_WIDTH-1:0] fill_addr_q;
  logic [DATA_WIDTH-1:0] fill_data_q;
  logic                  fill_hit_q;

  logic [INDEX_W-1:0]    cap_index;
  logic [TAG_W-1:0]      cap_tag;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  lookup_hit;
  logic                  mem_wr;
  logic                  req_ready_c;
  logic                  mem_req_c;
  logic                  fill_valid_c;

  assign cap_index  = cap_addr[OFFSET_W +: INDEX_W];
  assign cap_tag    = cap_addr[ADDR_WIDTH-1 -: TAG_W];
  assign lookup_hit = rd_valid && (rd_tag == cap_tag);

  l2_tag_store #(
    .NUM_SETS   (NUM_SETS),
    .INDEX_W    (INDEX_W),
    .TAG_W      (TAG_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (cap_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (mem_wr),
    .wr_index (cap_index),
    .wr_tag   (cap_tag),
    .wr_data  (bus.mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // mem_ack only matters in MEM_WAIT; req_valid only matters in IDLE.
  always_comb begin
    state_next   = state;
    req_ready_c  = 1'b0;
    mem_req_c    = 1'b0;
    fill_valid_c = 1'b0;
    mem_wr       = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        state_next = lookup_hit ? FILL : MEM_WAIT;
      end
      MEM_WAIT: begin
        mem_req_c = 1'b1;
        if (bus.mem_ack) begin
          mem_wr     = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        fill_valid_c = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The fill registers are only loaded when a line is ready, so they hold
  // their last value between strobes even though cap_addr moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr    <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      fill_hit_q  <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        cap_addr <= bus.req_addr;
      end
      if (state == LOOKUP) begin
        if (lookup_hit) begin
          fill_addr_q <= cap_addr;
          fill_data_q <= rd_data;
          fill_hit_q  <= 1'b1;
          if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
        end else begin
          if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
      end
      if (mem_wr) begin
        fill_addr_q <= cap_addr;
        fill_data_q <= bus.mem_rdata;
        fill_hit_q  <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.mem_req    = mem_req_c;
  assign bus.mem_addr   = cap_addr;
  assign bus.fill_valid = fill_valid_c;
  assign bus.fill_addr  = fill_addr_q;
  assign bus.fill_data  = fill_data_q;
  assign bus.fill_hit   = fill_hit_q;

endmodule

// File: tb/tb_l2_fill_ctrl.sv
// Testbench for l2_fill_ctrl. A transaction-level model of the L2 (per-set
// valid/tag/data arrays and hit/miss counts) predicts, cycle by cycle, what
// the controller outputs must be; a negedge process compares them. Directed
// sequences are followed by randomized traffic and a counter saturation run.
module tb_l2_fill_ctrl;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int SETS  = 16;
  localparam int BLOCK = 16;

  logic        clk;
  logic        rst;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  l2_fill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  l2_fill_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_SETS   (SETS),
    .BLOCK_SIZE (BLOCK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fill_strobes = 0;

  // Model of the L2 contents.
  bit          m_valid [SETS];
  int          m_tag   [SETS];
  logic [31:0] m_data  [SETS];

  // Expected outputs for the current cycle.
  logic          exp_ready;
  logic          exp_mem_req;
  logic [AW-1:0] exp_mem_addr;
  logic          exp_fill_valid;
  logic [AW-1:0] exp_fill_addr;
  logic [DW-1:0] exp_fill_data;
  logic          exp_fill_hit;
  logic [15:0]   exp_hit;
  logic [15:0]   exp_miss;

  function automatic int model_index(input logic [AW-1:0] a);
    return (int'(a) / BLOCK) % SETS;
  endfunction

  function automatic int model_tag(input logic [AW-1:0] a);
    return int'(a) / (BLOCK * SETS);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    exp_ready      = 1'b1;
    exp_mem_req    = 1'b0;
    exp_mem_addr   = '0;
    exp_fill_valid = 1'b0;
    exp_fill_addr  = '0;
    exp_fill_data  = '0;
    exp_fill_hit   = 1'b0;
    exp_hit        = '0;
    exp_miss       = '0;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    checkOutput("mem_req", 32'(bus.mem_req), 32'(exp_mem_req));
    checkOutput("fill_valid", 32'(bus.fill_valid), 32'(exp_fill_valid));
    checkOutput("fill_addr", 32'(bus.fill_addr), 32'(exp_fill_addr));
    checkOutput("fill_data", bus.fill_data, exp_fill_data);
    checkOutput("hit_count", 32'(hit_count), 32'(exp_hit));
    checkOutput("miss_count", 32'(miss_count), 32'(exp_miss));
    if (exp_mem_req || rst) checkOutput("mem_addr", 32'(bus.mem_addr), 32'(exp_mem_addr));
    if (exp_fill_valid || rst) checkOutput("fill_hit", 32'(bus.fill_hit), 32'(exp_fill_hit));
    if (bus.fill_valid === 1'b1) fill_strobes++;
  end

  // One full request; controller must be in IDLE on entry and is in IDLE on
  // return. With hold set, req_valid stays high for the next request.
  task automatic applyStimulus(input logic [AW-1:0] addr, input int delay,
                               input logic [31:0] rdata, input bit hold);
    int idx;
    int tg;
    bit hit;
    idx = model_index(addr);
    tg  = model_tag(addr);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    tick();
    if (!hold) bus.req_valid = 1'b0;
    exp_ready = 1'b0;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    tick();
    if (hit) begin
      if (exp_hit != 16'hFFFF) exp_hit = exp_hit + 16'd1;
      exp_fill_valid = 1'b1;
      exp_fill_addr  = addr;
      exp_fill_data  = m_data[idx];
      exp_fill_hit   = 1'b1;
    end else begin
      if (exp_miss != 16'hFFFF) exp_miss = exp_miss + 16'd1;
      exp_mem_req  = 1'b1;
      exp_mem_addr = addr;
      for (int i = 0; i < delay; i++) tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rdata;
      tick();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      exp_mem_req    = 1'b0;
      m_valid[idx]   = 1'b1;
      m_tag[idx]     = tg;
      m_data[idx]    = rdata;
      exp_fill_valid = 1'b1;
      exp_fill_addr  = addr;
      exp_fill_data  = rdata;
      exp_fill_hit   = 1'b0;
    end
    tick();
    exp_fill_valid = 1'b0;
    exp_ready      = 1'b1;
  endtask

  // Idle cycles, optionally with stray memory acks that must be ignored.
  task automatic idleCycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      bus.mem_ack   = stray;
      bus.mem_rdata = $urandom;
      tick();
    end
    bus.mem_ack = 1'b0;
  endtask

  // Start a request that misses, then reset while waiting on memory.
  task automatic resetMidWait(input logic [AW-1:0] addr, input int wait_cycles);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    tick();
    bus.req_valid = 1'b0;
    exp_ready = 1'b0;
    tick();
    exp_miss     = exp_miss + 16'd1;
    exp_mem_req  = 1'b1;
    exp_mem_addr = addr;
    for (int i = 0; i < wait_cycles; i++) tick();
    rst           = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    modelReset();
    tick();
    tick();
    bus.mem_ack = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int strobes_before;
    logic [AW-1:0] a;
    bit hold;

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    modelReset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    $display("[TB] reset released");

    // First miss on 0x120, memory answers after 3 cycles.
    applyStimulus(11'h120, 3, 32'hCAFEF00D, 1'b0);
    checkOutput("pin_first_fill_data", bus.fill_data, 32'hCAFEF00D);
    checkOutput("pin_first_miss_count", 32'(miss_count), 32'd1);
    checkOutput("pin_first_strobes", 32'(fill_strobes), 32'd1);

    // Repeat 0x120 hits in L2.
    applyStimulus(11'h120, 0, 32'h0, 1'b0);
    checkOutput("pin_hit_count", 32'(hit_count), 32'd1);
    checkOutput("pin_hit_data", bus.fill_data, 32'hCAFEF00D);
    checkOutput("pin_hit_strobes", 32'(fill_strobes), 32'd2);

    // Conflict in set 2 evicts 0x120, which then misses again.
    applyStimulus(11'h520, 1, 32'h11112222, 1'b0);
    checkOutput("pin_evict_data", bus.fill_data, 32'h11112222);
    applyStimulus(11'h120, 2, 32'hCAFEF00D, 1'b0);
    checkOutput("pin_evict_miss_count", 32'(miss_count), 32'd3);

    // req_valid held through a miss, then stray acks while idle.
    strobes_before = fill_strobes;
    applyStimulus(11'h720, 2, 32'hA5A5A5A5, 1'b1);
    applyStimulus(11'h120, 1, 32'h5A5A5A5A, 1'b0);
    idleCycles(4, 1'b1);
    checkOutput("pin_hold_strobes", 32'(fill_strobes - strobes_before), 32'd2);

    // Reset in the middle of a memory wait.
    resetMidWait(11'h320, 2);
    checkOutput("pin_rst_hit_count", 32'(hit_count), 32'd0);
    checkOutput("pin_rst_miss_count", 32'(miss_count), 32'd0);
    applyStimulus(11'h120, 0, 32'hCAFEF00D, 1'b0);
    checkOutput("pin_post_rst_miss", 32'(miss_count), 32'd1);

    // Randomized traffic over a few sets and tags.
    hold = 1'b0;
    for (int n = 0; n < 80; n++) begin
      a = 11'((($urandom % 3) << 8) | (($urandom % 4) << 4) | ($urandom % 16));
      hold = (n < 79) && (($urandom % 4) == 0);
      applyStimulus(a, int'($urandom % 6), $urandom, hold);
      if (!hold) idleCycles(int'($urandom % 4), ($urandom % 2) == 1);
    end
    bus.req_valid = 1'b0;

    // Saturation: preload the hit counter just below the limit.
    applyStimulus(11'h040, 1, 32'h0BADF00D, 1'b0);
    force dut.hit_count = 16'hFFFE;
    #1;
    release dut.hit_count;
    exp_hit = 16'hFFFE;
    tick();
    applyStimulus(11'h040, 0, 32'h0, 1'b0);
    applyStimulus(11'h040, 0, 32'h0, 1'b0);
    applyStimulus(11'h040, 0, 32'h0, 1'b0);
    checkOutput("pin_hit_saturated", 32'(hit_count), 32'h0000FFFF);
    idleCycles(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
